// File: rtl/opendap_swd_link_ctrl.sv
// opendap_swd_link_ctrl: SWD link state tracker and packet header decoder with protocol-error lockout.
// Optional OPENDAP_LINK_ERR_COUNT_EN adds a saturating err_count output.
module opendap_swd_link_ctrl #(
  parameter bit RESET_DORMANT = 1'b1,
  parameter int unsigned IDLE_MIN = 2
) (
  input  logic       swclk,
  input  logic       rst,
  input  logic       swdi_reg,
  input  logic       exit_dormant,
  input  logic       enter_dormant,
  input  logic       line_reset,
  input  logic       data_phase_active,
  output logic       dormant,
  output logic       link_active,
  output logic       lockout,
  output logic       hdr_valid,
  output logic       hdr_apndp,
  output logic       hdr_rnw,
  output logic [1:0] hdr_addr,
  output logic       proto_err
`ifdef OPENDAP_LINK_ERR_COUNT_EN
  ,output logic [7:0] err_count
`endif
);
  typedef enum logic [2:0] {
    S_DORMANT, S_RESET, S_IDLE, S_ACTIVE, S_HEADER, S_DATA, S_LOCKOUT
  } state_t;
  localparam logic [3:0] IMIN = 4'(IDLE_MIN);
  state_t state, nxt;
  logic [5:0] sh;
  logic [2:0] bit_ctr;
  logic [3:0] idle_ctr, idle_inc;
  logic hdr_done, hdr_ok, hdr_acc, hdr_fail;
  assign idle_inc = idle_ctr == 4'hf ? idle_ctr : idle_ctr + 4'd1;
  assign hdr_done = state == S_HEADER && bit_ctr == 3'd6;
  // sh holds APnDP..Stop (oldest in bit 0); swdi_reg is the Park bit
  assign hdr_ok = (sh[4] == ^sh[3:0]) && !sh[5] && swdi_reg;
  assign hdr_acc = hdr_done && nxt == S_DATA;
  assign hdr_fail = hdr_done && nxt == S_LOCKOUT;
  always_comb begin
    nxt = state;
    case (state)
      S_DORMANT: nxt = exit_dormant ? S_RESET : S_DORMANT;
      S_RESET:   nxt = swdi_reg ? S_RESET : (IMIN <= 4'd1 ? S_ACTIVE : S_IDLE);
      S_IDLE:    nxt = swdi_reg ? S_RESET : (idle_inc >= IMIN ? S_ACTIVE : S_IDLE);
      S_ACTIVE:  nxt = !data_phase_active && swdi_reg ? S_HEADER : S_ACTIVE;
      S_HEADER:  nxt = !hdr_done ? S_HEADER : (hdr_ok ? S_DATA : S_LOCKOUT);
      S_DATA:    nxt = !hdr_valid && !data_phase_active ? S_ACTIVE : S_DATA;
      default:   nxt = S_LOCKOUT;
    endcase
    if (state != S_DORMANT && line_reset) nxt = S_RESET;
    if (enter_dormant) nxt = S_DORMANT;
  end
  always_ff @(posedge swclk or posedge rst) begin
    if (rst) begin
      state <= RESET_DORMANT ? S_DORMANT : S_RESET;
      dormant <= RESET_DORMANT;
      link_active <= 1'b0;
      lockout <= 1'b0;
      hdr_valid <= 1'b0;
      proto_err <= 1'b0;
      hdr_apndp <= 1'b0;
      hdr_rnw <= 1'b0;
      hdr_addr <= 2'd0;
      sh <= 6'd0;
      bit_ctr <= 3'd0;
      idle_ctr <= 4'd0;
`ifdef OPENDAP_LINK_ERR_COUNT_EN
      err_count <= 8'd0;
`endif
    end else begin
      state <= nxt;
      dormant <= nxt == S_DORMANT;
      link_active <= nxt inside {S_ACTIVE, S_HEADER, S_DATA};
      lockout <= nxt == S_LOCKOUT;
      hdr_valid <= hdr_acc;
      proto_err <= hdr_fail;
      sh <= {swdi_reg, sh[5:1]};
      bit_ctr <= state == S_HEADER ? (bit_ctr == 3'd7 ? bit_ctr : bit_ctr + 3'd1) : 3'd0;
      idle_ctr <= state == S_IDLE ? idle_inc : 4'd1;
      if (hdr_acc) {hdr_addr, hdr_rnw, hdr_apndp} <= {sh[3:2], sh[1], sh[0]};
`ifdef OPENDAP_LINK_ERR_COUNT_EN
      if (hdr_fail && err_count != 8'hff) err_count <= err_count + 8'd1;
`endif
    end
  end
endmodule

// File: tb/tb_opendap_swd_link_ctrl.sv
// tb_opendap_swd_link_ctrl: vector table, reset/abort sequences and random stimulus
// against a behavioural link model.
module tb_opendap_swd_link_ctrl;
  localparam int IMIN = 2;
  logic swclk, rst, swdi_reg, exit_dormant, enter_dormant, line_reset, data_phase_active;
  logic dormant, link_active, lockout, hdr_valid, hdr_apndp, hdr_rnw, proto_err;
  logic [1:0] hdr_addr;
`ifdef OPENDAP_LINK_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  opendap_swd_link_ctrl #(.RESET_DORMANT(1'b1), .IDLE_MIN(IMIN)) dut (
    .swclk(swclk), .rst(rst), .swdi_reg(swdi_reg), .exit_dormant(exit_dormant),
    .enter_dormant(enter_dormant), .line_reset(line_reset),
    .data_phase_active(data_phase_active), .dormant(dormant), .link_active(link_active),
    .lockout(lockout), .hdr_valid(hdr_valid), .hdr_apndp(hdr_apndp), .hdr_rnw(hdr_rnw),
    .hdr_addr(hdr_addr), .proto_err(proto_err)
`ifdef OPENDAP_LINK_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  initial swclk = 1'b0;
  always #5 swclk = ~swclk;

  int n_cmp = 0, n_bad = 0;

  // Behavioural model: link condition flags plus the header bits collected so far
  bit m_dorm, m_lock, m_sync, m_data, m_hv, m_pe, m_ap, m_rnw;
  bit [1:0] m_addr;
  int m_zeros, m_errs;
  bit q[$];

  typedef struct {
    bit sd, xd, ed, lr, dpa;
    bit dorm, link, lock, hv, pe;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_dorm = 1; m_lock = 0; m_sync = 0; m_data = 0; m_hv = 0; m_pe = 0;
    m_ap = 0; m_rnw = 0; m_addr = 0; m_zeros = 0; m_errs = 0;
    q.delete();
  endtask

  task automatic model(input bit sd, input bit xd, input bit ed, input bit lr, input bit dpa);
    bit phv;
    phv = m_hv; m_hv = 0; m_pe = 0;
    if (ed) begin
      m_dorm = 1; m_lock = 0; m_sync = 0; m_data = 0; q.delete();
    end else if (m_dorm) begin
      if (xd) begin m_dorm = 0; m_zeros = 0; end
    end else if (lr) begin
      m_lock = 0; m_sync = 0; m_data = 0; m_zeros = 0; q.delete();
    end else if (m_lock) begin
    end else if (!m_sync) begin
      m_zeros = sd ? 0 : m_zeros + 1;
      m_sync = m_zeros >= IMIN;
    end else if (m_data) begin
      m_data = phv || dpa;
    end else if (q.size() > 0) begin
      q.push_back(sd);
      if (q.size() == 8) begin
        if (q[5] == (q[1] ^ q[2] ^ q[3] ^ q[4]) && !q[6] && q[7]) begin
          m_hv = 1; m_data = 1; m_ap = q[1]; m_rnw = q[2]; m_addr = {q[4], q[3]};
        end else begin
          m_pe = 1; m_lock = 1;
          if (m_errs < 255) m_errs++;
        end
        q.delete();
      end
    end else if (!dpa && sd) begin
      q.push_back(1'b1);
    end
  endtask

  task automatic chk_all();
    chk("dormant", dormant, m_dorm);
    chk("link_active", link_active, !m_dorm && !m_lock && m_sync);
    chk("lockout", lockout, m_lock);
    chk("hdr_valid", hdr_valid, m_hv);
    chk("proto_err", proto_err, m_pe);
    chk("hdr_apndp", hdr_apndp, m_ap);
    chk("hdr_rnw", hdr_rnw, m_rnw);
    chk("hdr_addr", hdr_addr, m_addr);
`ifdef OPENDAP_LINK_ERR_COUNT_EN
    chk("err_count", err_count, 8'(m_errs));
`endif
  endtask

  task automatic step(input bit sd, input bit xd, input bit ed, input bit lr, input bit dpa);
    swdi_reg = sd; exit_dormant = xd; enter_dormant = ed; line_reset = lr;
    data_phase_active = dpa;
    @(posedge swclk);
    #1;
    model(sd, xd, ed, lr, dpa);
    chk_all();
  endtask

  task automatic send(input bit [7:0] b);
    for (int i = 7; i >= 0; i--) step(b[i], 0, 0, 0, 0);
  endtask

  task automatic add(input bit sd, input bit xd, input bit ed, input bit lr, input bit dpa,
                     input bit dorm, input bit link, input bit lock, input bit hv, input bit pe);
    tv.push_back('{sd, xd, ed, lr, dpa, dorm, link, lock, hv, pe});
  endtask

  // Header in transmission order (bit 7 = start bit first)
  task automatic add_hdr(input bit [7:0] b, input bit l, input bit k,
                         input bit ll, input bit kl, input bit hl, input bit pl);
    for (int i = 7; i > 0; i--) add(b[i], 0, 0, 0, 0, 0, l, k, 0, 0);
    add(b[0], 0, 0, 0, 0, 0, ll, kl, hl, pl);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; swdi_reg = 0; exit_dormant = 0; enter_dormant = 0; line_reset = 0;
    data_phase_active = 0;
    mreset();
    repeat (2) @(posedge swclk);
    #1;
    chk_all();
    #3 rst = 0;

    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 50; i++) step(1, 0, 0, 1, 0);

    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_hdr(8'b10100101, 1, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_hdr(8'b11011001, 1, 0, 0, 1, 0, 1);
    add_hdr(8'b10100101, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_hdr(8'b11011101, 1, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    foreach (tv[i]) begin
      step(tv[i].sd, tv[i].xd, tv[i].ed, tv[i].lr, tv[i].dpa);
      chk($sformatf("tv%0d_dormant", i), dormant, tv[i].dorm);
      chk($sformatf("tv%0d_link", i), link_active, tv[i].link);
      chk($sformatf("tv%0d_lockout", i), lockout, tv[i].lock);
      chk($sformatf("tv%0d_hdr_valid", i), hdr_valid, tv[i].hv);
      chk($sformatf("tv%0d_proto_err", i), proto_err, tv[i].pe);
    end
    chk("ap_write_apndp", hdr_apndp, 1);
    chk("ap_write_rnw", hdr_rnw, 0);
    chk("ap_write_addr", hdr_addr, 2'd3);

    // Asynchronous reset right after an accepted header must kill the pulse at once
    send(8'b10100101);
    chk("pre_rst_hdr_valid", hdr_valid, 1);
    rst = 1;
    #1;
    mreset();
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_dormant", dormant, 1);
    chk("rst_link", link_active, 0);
    chk("rst_rnw", hdr_rnw, 0);
    @(posedge swclk);
    #3 rst = 0;
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("reup_link", link_active, 1);

    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0);

`ifdef OPENDAP_LINK_ERR_COUNT_EN
    step(1, 1, 0, 0, 0);
    for (int k = 0; k < 260; k++) begin
      step(1, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      send(8'b11011001);
    end
    chk("err_count_sat", err_count, 8'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/opendap_swd_link_ctrl.md
Name: opendap_swd_link_ctrl

Overview:
- Downstream neighbour of the dormant/line-reset monitor on the SWCLK domain.
- Consumes the monitor's dormant-entry, dormant-exit and line-reset events plus the registered SWDIO sample, and tracks the SWD link state.
- Decodes 8-bit SWD packet headers and hands validated headers to the serial data engine.
- Enters protocol-error lockout on malformed headers; exits lockout only on line reset or dormant entry.

Parameters:
- RESET_DORMANT, 1, state after reset: 1 = DORMANT, 0 = RESET.
- IDLE_MIN, 2, consecutive low cycles required after line reset before headers are accepted (range 1..15).

Ports:
- swclk  input  1  SWD clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- swdi_reg  input  1  registered SWDIO sample, the same signal the monitor sees.
- exit_dormant  input  1  single-cycle pulse from the dormant monitor.
- enter_dormant  input  1  single-cycle pulse from the dormant monitor.
- line_reset  input  1  level from the monitor, high while the line-reset condition holds.
- data_phase_active  input  1  serial engine busy with ack/turnaround/data; driven high no later than the cycle after hdr_valid.
- dormant  output  1  link in DORMANT.
- link_active  output  1  state is ACTIVE, HEADER or DATA.
- lockout  output  1  state is LOCKOUT.
- hdr_valid  output  1  one-cycle pulse, header accepted.
- hdr_apndp  output  1  APnDP of last accepted header.
- hdr_rnw  output  1  RnW of last accepted header.
- hdr_addr  output  2  A[3:2] of last accepted header.
- proto_err  output  1  one-cycle pulse on malformed header.

Behaviour:
- Reset values:
  - state = DORMANT if RESET_DORMANT, else RESET.
  - dormant = RESET_DORMANT.
  - link_active, lockout, hdr_valid, proto_err = 0.
  - hdr_apndp, hdr_rnw, hdr_addr = 0.
  - All outputs are registered.
- States: DORMANT, RESET, IDLE_WAIT, ACTIVE, HEADER, DATA, LOCKOUT.
- Global priority, evaluated every cycle:
  1. enter_dormant → DORMANT from any state.
  2. In any non-DORMANT state, line_reset → RESET.
  3. Otherwise, the per-state rules below.
- DORMANT: all inputs except the two dormant pulses are ignored. exit_dormant → RESET. line_reset does not exit DORMANT.
- RESET:
  - swdi_reg = 1 → stay.
  - swdi_reg = 0 → IDLE_WAIT with idle_ctr = 1.
  - If IDLE_MIN = 1, go directly to ACTIVE.
- IDLE_WAIT:
  - swdi_reg = 0 → idle_ctr + 1; on reaching IDLE_MIN → ACTIVE.
  - swdi_reg = 1 → RESET. No header is accepted and no error is flagged.
- ACTIVE:
  - data_phase_active = 1 → hold.
  - Otherwise swdi_reg = 1 is a start bit → HEADER, bit_ctr = 0.
  - swdi_reg = 0 is idle → stay.
- HEADER: shift in 7 bits, LSB-first order: APnDP, RnW, A2, A3, Parity, Stop, Park. On the 7th bit (Park), check:
  - Parity == APnDP^RnW^A2^A3.
  - Stop == 0.
  - Park == 1.
- Header pass:
  - Next cycle: hdr_valid = 1, header fields updated, state → DATA.
  - Field outputs hold until the next accepted header.
  - Latency: hdr_valid rises on the swclk edge after the Park bit is presented on swdi_reg.
- Header fail: next cycle proto_err = 1, state → LOCKOUT; header fields unchanged.
- DATA:
  - The line is ignored in the cycle hdr_valid is high.
  - From the following cycle, data_phase_active = 0 → ACTIVE.
  - Any start bit seen while data_phase_active = 1 is ignored.
- LOCKOUT: the line is ignored; only line_reset (→ RESET) or enter_dormant (→ DORMANT) exit.
- Simultaneous events:
  - enter_dormant and exit_dormant together → DORMANT.
  - line_reset during HEADER or DATA aborts: no hdr_valid, no proto_err.
- rst mid-operation: immediately returns to the reset values; pulses are never stretched across reset.
- bit_ctr is 3 bits and idle_ctr is 4 bits; both saturate and never wrap.

Optional Feature:
- Macro: OPENDAP_LINK_ERR_COUNT_EN.
- Defined:
  - Adds output err_count [7:0], incremented on each proto_err pulse.
  - Saturates at 255; cleared only by rst.
  - Updates in the same cycle proto_err is asserted.
- Undefined: err_count is absent from the port list and no counter logic is built.

Test Plan:
- rst released with RESET_DORMANT = 1; drive exit_dormant pulse, ≥50 ones, then 2 zeros → dormant 1→0, link_active = 1 on the edge after the 2nd zero.
- From ACTIVE, send header bits 1,0,1,0,0,1,0,1 (DP read IDCODE) → hdr_valid pulse 1 cycle after Park; hdr_apndp = 0, hdr_rnw = 1, hdr_addr = 0; state DATA.
- Send header 1,1,0,1,1,0,0,1 (bad parity) → proto_err pulse, lockout = 1; further valid headers produce no hdr_valid until ≥50 ones + 2 zeros.
- Assert line_reset after 4 header bits → no hdr_valid, no proto_err; state RESET, link_active = 0.
- enter_dormant pulse during DATA with data_phase_active = 1 → dormant = 1 next cycle; subsequent line_reset ignored.
- With OPENDAP_LINK_ERR_COUNT_EN: 260 bad headers, each separated by line reset + 2 idles → err_count = 255.
